// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM arbiter and its round-robin picker.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 16;
  localparam int MEM_DEPTH_DEF = 1025;

  // Width of a core index; never narrower than one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of mask at or after ptr, wrapping.
module rr_picker
  import dram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = grant_w(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [GW-1:0] ptr,
  output logic          valid,
  output logic [GW-1:0] idx
);

  always_comb begin
    logic [GW:0] cand;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // One extra bit lets ptr+i exceed N-1 before the single wrap subtraction.
    for (int unsigned i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (GW+1)'(i);
      if (cand >= (GW+1)'(N)) begin
        cand = cand - (GW+1)'(N);
      end
      if (!valid && mask[cand[GW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one single-port DRAM among NUM_CORES cores, one transaction in flight.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_done,
  output logic                          core_err,
  output logic [DATA_W-1:0]             core_rdata,
  output logic [$clog2(NUM_CORES)-1:0]  grant_id,
  output logic                          busy,
  output logic                          dram_write_en,
  output logic [ADDR_W-1:0]             dram_addr,
  output logic [DATA_W-1:0]             dram_data_in,
  input  logic [DATA_W-1:0]             dram_data_out
);

  localparam int GRANT_W = grant_w(NUM_CORES);

  arb_state_e             state_q, state_d;
  logic [GRANT_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0]     grant_q, grant_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   oor_q, oor_d;
  logic [NUM_CORES-1:0]   done_q, done_d;
  logic                   err_q, err_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic [NUM_CORES-1:0]   elig_mask;
  logic                   pick_valid;
  logic [GRANT_W-1:0]     pick_idx;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;

  // A core whose done is pulsing still shows its old req; masking it avoids a stale regrant.
  assign elig_mask = core_req & ~done_q;

  rr_picker #(
    .N  (NUM_CORES),
    .GW (GRANT_W)
  ) u_picker (
    .mask  (elig_mask),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign sel_addr  = core_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = core_wdata[int'(pick_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    oor_d    = oor_q;
    done_d   = '0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          we_d    = core_we[pick_idx];
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          oor_d   = (32'(sel_addr) >= 32'(MEM_DEPTH));
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        done_d[grant_q] = 1'b1;
        err_d           = oor_q;
        if (!we_q) begin
          rdata_d = oor_q ? '0 : dram_data_out;
        end
        rr_ptr_d = (grant_q == GRANT_W'(NUM_CORES-1)) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      oor_q    <= 1'b0;
      done_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      oor_q    <= oor_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Decoded straight from registers so an async reset kills the write strobe at once.
  assign dram_write_en = (state_q == ACCESS) & we_q & ~oor_q;
  assign dram_addr     = addr_q;
  assign dram_data_in  = wdata_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_q;
  assign core_done     = done_q;
  assign core_err      = err_q;
  assign core_rdata    = rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed self-checking bench for dram_arbiter with a behavioural registered-read DRAM.
module tb_dram_arbiter;

  localparam int NC    = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 1025;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NC-1:0]        core_req;
  logic [NC-1:0]        core_we;
  logic [NC*AW-1:0]     core_addr;
  logic [NC*DW-1:0]     core_wdata;
  logic [NC-1:0]        core_done;
  logic                 core_err;
  logic [DW-1:0]        core_rdata;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 dram_write_en;
  logic [AW-1:0]        dram_addr;
  logic [DW-1:0]        dram_data_in;
  logic [DW-1:0]        dram_data_out = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int wen_count = 0;

  logic [DW-1:0] mem [0:DEPTH-1];

  always #5 clk = ~clk;

  dram_arbiter #(
    .NUM_CORES (NC),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core_req      (core_req),
    .core_we       (core_we),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_done     (core_done),
    .core_err      (core_err),
    .core_rdata    (core_rdata),
    .grant_id      (grant_id),
    .busy          (busy),
    .dram_write_en (dram_write_en),
    .dram_addr     (dram_addr),
    .dram_data_in  (dram_data_in),
    .dram_data_out (dram_data_out)
  );

  // Out-of-range reads return a poison word so the arbiter's zeroing is visible.
  always @(posedge clk) begin
    if (dram_write_en && dram_addr < 16'(DEPTH)) mem[dram_addr[10:0]] <= dram_data_in;
    dram_data_out <= (dram_addr < 16'(DEPTH)) ? mem[dram_addr[10:0]] : 16'hDEAD;
    if (dram_write_en) wen_count <= wen_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input int k, input logic we, input logic [15:0] a, input logic [15:0] d,
                     output logic [15:0] rd, output logic er, output logic [NC-1:0] dn, output int lat);
    core_we[k] = we;
    core_addr[k*AW +: AW] = a;
    core_wdata[k*DW +: DW] = d;
    core_req[k] = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!core_done[k] && lat < 20);
    rd = core_rdata;
    er = core_err;
    dn = core_done;
    core_req[k] = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0]   rd;
    logic          er;
    logic [NC-1:0] dn;
    int            lat;
    int            w0;
    int            cyc;
    int            nd;
    int            order [0:3];
    logic [15:0]   rds   [0:3];
    int            when  [0:3];

    rst = 1'b1;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    tick(); tick();
    check("reset_busy",  32'(busy), 0);
    check("reset_done",  32'(core_done), 0);
    check("reset_err",   32'(core_err), 0);
    check("reset_rdata", 32'(core_rdata), 0);
    check("reset_grant", 32'(grant_id), 0);
    check("reset_wen",   32'(dram_write_en), 0);
    check("reset_addr",  32'(dram_addr), 0);
    rst = 1'b0;
    tick();

    // Single write then read on core 2
    w0 = wen_count;
    txn(2, 1'b1, 16'd5, 16'h00AA, rd, er, dn, lat);
    check("wr5_latency", 32'(lat), 3);
    check("wr5_done",    32'(dn), 32'h4);
    check("wr5_err",     32'(er), 0);
    check("wr5_wen_cnt", 32'(wen_count - w0), 1);
    txn(2, 1'b0, 16'd5, 16'h0000, rd, er, dn, lat);
    check("rd5_latency", 32'(lat), 3);
    check("rd5_rdata",   32'(rd), 32'h00AA);
    check("rd5_err",     32'(er), 0);

    // Out-of-range write and read on core 1
    w0 = wen_count;
    txn(1, 1'b1, 16'd1025, 16'hFFFF, rd, er, dn, lat);
    check("oor_wr_latency", 32'(lat), 3);
    check("oor_wr_done",    32'(dn), 32'h2);
    check("oor_wr_err",     32'(er), 1);
    check("oor_wr_no_wen",  32'(wen_count - w0), 0);
    check("oor_wr_rdata_kept", 32'(rd), 32'h00AA);
    txn(1, 1'b0, 16'd1025, 16'h0000, rd, er, dn, lat);
    check("oor_rd_rdata", 32'(rd), 0);
    check("oor_rd_err",   32'(er), 1);
    check("boundary_rd_1024_err_lat", 32'(lat), 3);
    txn(1, 1'b1, 16'd1024, 16'h0BEE, rd, er, dn, lat);
    check("in_range_1024_err", 32'(er), 0);

    // Preload words 10..13 from core 3; rr_ptr then wraps to 0
    for (int i = 0; i < 4; i++) begin
      txn(3, 1'b1, 16'(10 + i), 16'(i + 1), rd, er, dn, lat);
    end

    // Contention: all four cores read together
    for (int k = 0; k < NC; k++) begin
      core_we[k] = 1'b0;
      core_addr[k*AW +: AW] = 16'(10 + k);
    end
    core_req = 4'b1111;
    cyc = 0; nd = 0;
    while (nd < 4 && cyc < 40) begin
      tick();
      cyc++;
      for (int k = 0; k < NC; k++) begin
        if (core_done[k]) begin
          if (nd < 4) begin
            order[nd] = k; rds[nd] = core_rdata; when[nd] = cyc;
          end
          nd++;
          core_req[k] = 1'b0;
        end
      end
    end
    check("cont_done_count", 32'(nd), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont_order_%0d", i), 32'(order[i]), 32'(i));
      check($sformatf("cont_rdata_%0d", i), 32'(rds[i]), 32'(i + 1));
      check($sformatf("cont_cycle_%0d", i), 32'(when[i]), 32'(3 * (i + 1)));
    end
    tick();
    check("cont_idle_after", 32'(busy), 0);
    check("cont_no_extra_done", 32'(core_done), 0);

    // Fairness: core 0 keeps requesting, core 3 asks once; rr_ptr starts at 0
    core_addr[0*AW +: AW] = 16'd10;
    core_addr[3*AW +: AW] = 16'd13;
    core_req[0] = 1'b1;
    core_req[3] = 1'b1;
    cyc = 0; nd = 0;
    while (nd < 3 && cyc < 40) begin
      tick();
      cyc++;
      for (int k = 0; k < NC; k++) begin
        if (core_done[k]) begin
          if (nd < 3) begin
            order[nd] = k; rds[nd] = core_rdata; when[nd] = cyc;
          end
          nd++;
          if (k == 3) core_req[3] = 1'b0;
        end
      end
    end
    core_req[0] = 1'b0;
    check("fair_done_count", 32'(nd), 3);
    check("fair_order_0", 32'(order[0]), 0);
    check("fair_order_1", 32'(order[1]), 3);
    check("fair_order_2", 32'(order[2]), 0);
    check("fair_rdata_1", 32'(rds[1]), 32'h4);
    check("fair_cycle_1", 32'(when[1]), 6);
    check("fair_cycle_2", 32'(when[2]), 9);
    tick();

    // Reset during ACCESS of a write must abort it
    txn(2, 1'b1, 16'd7, 16'h1234, rd, er, dn, lat);
    core_we[2] = 1'b1;
    core_addr[2*AW +: AW] = 16'd7;
    core_wdata[2*DW +: DW] = 16'h5678;
    core_req[2] = 1'b1;
    tick();
    check("acc_busy",   32'(busy), 1);
    check("acc_grant",  32'(grant_id), 2);
    check("acc_wen",    32'(dram_write_en), 1);
    check("acc_addr",   32'(dram_addr), 7);
    check("acc_wdata",  32'(dram_data_in), 32'h5678);
    #2;
    rst = 1'b1;
    #1;
    check("rst_wen_now",  32'(dram_write_en), 0);
    check("rst_busy_now", 32'(busy), 0);
    check("rst_grant",    32'(grant_id), 0);
    check("rst_done",     32'(core_done), 0);
    check("rst_err",      32'(core_err), 0);
    check("rst_rdata",    32'(core_rdata), 0);
    check("rst_addr",     32'(dram_addr), 0);
    core_req[2] = 1'b0;
    tick();
    check("rst_no_done", 32'(core_done), 0);
    rst = 1'b0;
    tick();
    check("post_rst_no_done", 32'(core_done), 0);
    txn(2, 1'b0, 16'd7, 16'h0000, rd, er, dn, lat);
    check("rst_word_kept", 32'(rd), 32'h1234);
    check("rst_word_err",  32'(er), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single-port shared DRAM (16-bit address/data, one access per clock, registered read data, write and read mutually exclusive per cycle) among NUM_CORES processor cores.
- Round-robin arbitration; one transaction in flight at a time.
- Each core gets a per-core done pulse with read data and an out-of-range error flag.
- Sits between the core load/store units and the DRAM instance at top level.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_DEPTH, 1025, number of valid DRAM words; addresses >= MEM_DEPTH are out of range

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- core_req  input  NUM_CORES  per-core request, held high until done
- core_we  input  NUM_CORES  per-core 1=write, 0=read; valid while req high
- core_addr  input  NUM_CORES*ADDR_W  flattened; core k uses bits [k*ADDR_W +: ADDR_W]
- core_wdata  input  NUM_CORES*DATA_W  flattened write data, same slicing
- core_done  output  NUM_CORES  one-cycle completion pulse, one-hot or zero
- core_err  output  1  valid with core_done; 1 = address out of range
- core_rdata  output  DATA_W  read data broadcast to all cores, valid with core_done
- grant_id  output  $clog2(NUM_CORES)  index of the core currently being served
- busy  output  1  high in ACCESS and RESP
- dram_write_en  output  1  to DRAM write_en
- dram_addr  output  ADDR_W  to DRAM addr
- dram_data_in  output  DATA_W  to DRAM data_in
- dram_data_out  input  DATA_W  from DRAM data_out; valid the cycle after a read edge

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Eligible mask = core_req & ~core_done.
  - If nonzero, pick the first set bit at or after rr_ptr, wrapping modulo NUM_CORES.
  - Latch winner index into grant_id, plus its we, addr and wdata. Set oor = (addr >= MEM_DEPTH). Go to ACCESS.
- ACCESS:
  - dram_addr = latched addr; dram_data_in = latched wdata.
  - dram_write_en = latched we & ~oor, decoded from the state register so async reset removes it immediately.
  - DRAM performs the access at the closing edge. Go to RESP.
- RESP: at the closing edge:
  - core_done[grant_id] <= 1.
  - core_err <= oor.
  - core_rdata <= (read & ~oor) ? dram_data_out : 0; writes leave core_rdata unchanged.
  - rr_ptr <= (grant_id+1) mod NUM_CORES. Go to IDLE.
- Timing and latency:
  - core_done is registered and high for exactly the one cycle after RESP, which is an IDLE cycle.
  - Latency from req sampled in IDLE to done visible: 3 edges.
  - Back-to-back grant is possible in that same IDLE cycle for a different core.
- Handshake:
  - Core holds req/we/addr/wdata stable until it sees its done.
  - It may drop req, or raise it again for a new transaction, in the cycle after done.
  - The done mask prevents re-granting the same core on a stale req.
- dram_write_en is 0 in IDLE and RESP. The DRAM then performs harmless reads at dram_addr, which holds its last latched value (0 after reset).
- Out of range: write suppressed, read returns 0, done still pulses with core_err=1.
- Request dropped mid-transaction: the transaction still completes and done still pulses (protocol violation, no recovery).
- Reset, at any time:
  - state=IDLE, rr_ptr=0, grant_id=0.
  - core_done=0, core_err=0, core_rdata=0.
  - latched addr/wdata/we=0, so dram_write_en=0 immediately.
  - An in-flight transaction is abandoned with no done pulse.
- Fairness: with all cores requesting continuously, grants rotate 0,1,2,3,0,… Each core waits at most NUM_CORES transactions.

Decomposition:
- Shared package dram_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - ADDR_W/DATA_W defaults
  - MEM_DEPTH constant
  - GRANT_W = $clog2(NUM_CORES) helper
- One combinational sub-module rr_picker (mask, rr_ptr -> valid, index). Reusable by later cache and interconnect arbiters.

Test Plan:
- Reset: assert rst mid-ACCESS with a write pending -> dram_write_en drops the same cycle; all outputs 0; the DRAM word is unchanged.
- Single write then read, core 2: write addr 5 data 0x00AA -> done[2] 3 edges later, err=0; then read addr 5 -> core_rdata=0x00AA with done[2].
- Contention: cores 0–3 request together (reads of addrs 10–13 preloaded 1..4) -> done order 0,1,2,3 with rdata 1,2,3,4; each core granted exactly once; rr_ptr ends at 0.
- Fairness: core 0 re-requests every cycle after its done, core 3 requests once -> core 3 is granted right after core 0's current transaction, not starved.
- Out of range: core 1 writes addr 1025 data 0xFFFF -> dram_write_en never high, done[1] with err=1; a core 1 read of addr 1025 -> rdata 0, err=1.
- Back-to-back: core 0 done at cycle N and core 1 requesting -> core 1 granted at the IDLE cycle N (no bubble); core 0 not regranted on its stale req.
